// File: rtl/inst_fetch.sv
// Instruction-fetch front end: owns the PC, reads the combinational ROM and
// buffers fetched words in a small prefetch queue presented to decode.
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          ROM_AW   = 6,
  parameter int          QDEPTH   = 2
) (
  input  logic              clk,
  input  logic              rst,
  output logic              rom_ce,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [31:0]       rom_inst,
  input  logic              br_valid,
  input  logic [31:0]       br_target,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_pc,
  output logic [31:0]       out_inst
);

  localparam int              PW       = $clog2(QDEPTH);
  localparam logic [PW:0]     FULL_CNT = (PW+1)'(QDEPTH);

  logic              rom_ce_q;
  logic [31:0]       pc_q, pc_d;
  logic [PW-1:0]     rd_q, rd_d, wr_q, wr_d;
  logic [PW:0]       cnt_q, cnt_d;
  logic [31:0]       qpc_q   [QDEPTH];
  logic [31:0]       qinst_q [QDEPTH];
  logic              empty_s, full_s, pop_s, fetch_s;

  assign empty_s = (cnt_q == '0);
  assign full_s  = (cnt_q == FULL_CNT);
  assign pop_s   = out_valid & out_ready;
  assign fetch_s = rom_ce_q & ~br_valid & (~full_s | pop_s);

  assign rom_ce    = rom_ce_q;
  assign rom_addr  = pc_q[ROM_AW+1:2];
  assign out_valid = ~empty_s;
  assign out_pc    = empty_s ? 32'h0000_0000 : qpc_q[rd_q];
  assign out_inst  = empty_s ? 32'h0000_0000 : qinst_q[rd_q];

  // Next PC, queue pointers and occupancy; a redirect clears the queue.
  always_comb begin
    pc_d  = pc_q;
    rd_d  = rd_q;
    wr_d  = wr_q;
    cnt_d = cnt_q;
    if (br_valid) begin
      pc_d  = {br_target[31:2], 2'b00};
      rd_d  = '0;
      wr_d  = '0;
      cnt_d = '0;
    end else begin
      if (fetch_s) begin
        pc_d = pc_q + 32'd4;
        wr_d = wr_q + 1'b1;
      end else begin
        pc_d = pc_q;
        wr_d = wr_q;
      end
      if (pop_s) begin
        rd_d = rd_q + 1'b1;
      end else begin
        rd_d = rd_q;
      end
      cnt_d = cnt_q + {{PW{1'b0}}, fetch_s} - {{PW{1'b0}}, pop_s};
    end
  end

  // State registers and queue storage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rom_ce_q <= 1'b0;
      pc_q     <= RESET_PC;
      rd_q     <= '0;
      wr_q     <= '0;
      cnt_q    <= '0;
      for (int i = 0; i < QDEPTH; i++) begin
        qpc_q[i]   <= 32'h0000_0000;
        qinst_q[i] <= 32'h0000_0000;
      end
    end else begin
      rom_ce_q <= 1'b1;
      pc_q     <= pc_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      cnt_q    <= cnt_d;
      if (fetch_s) begin
        qpc_q[wr_q]   <= pc_q;
        qinst_q[wr_q] <= rom_inst;
      end
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: a queue-based reference model tracks the
// expected PC stream while randomized ready/redirect traffic is applied.
module tb_inst_fetch;

  localparam int AW = 6;
  localparam int QD = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rom_ce;
  logic [AW-1:0] rom_addr;
  logic [31:0]   rom_inst;
  logic          br_valid = 1'b0;
  logic [31:0]   br_target = 32'h0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [31:0]   out_pc;
  logic [31:0]   out_inst;

  logic [31:0]   rom [1<<AW];
  assign rom_inst = rom_ce ? rom[rom_addr] : 32'h0;

  inst_fetch #(.RESET_PC(32'h0), .ROM_AW(AW), .QDEPTH(QD)) dut (
    .clk(clk), .rst(rst), .rom_ce(rom_ce), .rom_addr(rom_addr),
    .rom_inst(rom_inst), .br_valid(br_valid), .br_target(br_target),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_inst(out_inst)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: list of {pc, inst} pending for decode, fetch PC, enable.
  logic [63:0] mq [$];
  logic [31:0] m_pc;
  logic        m_ce;
  logic [71:0] obs, exp;

  function automatic logic [71:0] exp_obs();
    logic [63:0] h;
    h = (mq.size() != 0) ? mq[0] : 64'h0;
    return {(mq.size() != 0), h, m_pc[AW+1:2], m_ce};
  endfunction

  function automatic logic [71:0] get_obs();
    return {out_valid, out_pc, out_inst, rom_addr, rom_ce};
  endfunction

  task automatic model_step(input logic b, input logic [31:0] t, input logic r);
    logic pop, fetch;
    logic [63:0] ent;
    pop   = (mq.size() != 0) && r;
    fetch = m_ce && !b && ((mq.size() < QD) || pop);
    ent   = {m_pc, rom[m_pc[AW+1:2]]};
    if (pop) void'(mq.pop_front());
    if (b) begin
      mq.delete();
      m_pc = {t[31:2], 2'b00};
    end else if (fetch) begin
      mq.push_back(ent);
      m_pc = m_pc + 32'd4;
    end
    m_ce = 1'b1;
  endtask

  // Apply one cycle of inputs from a falling edge to the next falling edge.
  task automatic tick(input logic b, input logic [31:0] t, input logic r);
    br_valid = b; br_target = t; out_ready = r;
    @(posedge clk);
    if (!rst) model_step(b, t, r);
    @(negedge clk);
    br_valid = 1'b0;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    mq.delete(); m_pc = 32'h0; m_ce = 1'b0;
    repeat (n) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    do_reset(3);
    out_ready = 1'b1;
    checks++;
    if ({rom_ce, out_valid, out_pc, out_inst, rom_addr} !== {2'b00, 64'h0, 6'd0}) begin
      errors++; $display("FAIL reset_values: got ce=%b v=%b pc=%h inst=%h addr=%0d", rom_ce, out_valid, out_pc, out_inst, rom_addr);
    end
    tick(1'b0, 32'h0, 1'b1);
    checks++;
    if (rom_ce !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_ce_rise: got ce=%b v=%b expected ce=1 v=0", rom_ce, out_valid);
    end
    for (int k = 0; k < 4; k++) begin
      tick(1'b0, 32'h0, 1'b1);
      checks++;
      if (out_valid !== 1'b1 || out_pc !== 32'(4*k) || out_inst !== rom[k]) begin
        errors++; $display("FAIL reset_stream: got v=%b pc=%h inst=%h expected pc=%h inst=%h", out_valid, out_pc, out_inst, 32'(4*k), rom[k]);
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset(2);
    for (int k = 0; k < 6; k++) tick(1'b0, 32'h0, 1'b0);
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'h0 || rom_addr !== 6'd2) begin
      errors++; $display("FAIL bp_hold: got v=%b pc=%h addr=%0d expected v=1 pc=0 addr=2", out_valid, out_pc, rom_addr);
    end
    tick(1'b0, 32'h0, 1'b1);
    checks++;
    if (out_pc !== 32'h4 || rom_addr !== 6'd3) begin
      errors++; $display("FAIL bp_release: got pc=%h addr=%0d expected pc=4 addr=3", out_pc, rom_addr);
    end
    for (int k = 0; k < 3; k++) tick(1'b0, 32'h0, 1'b0);
    obs = get_obs(); exp = exp_obs(); checks++;
    if (obs !== exp) begin
      errors++; $display("FAIL bp_model: got %h expected %h", obs, exp);
    end
  endtask

  task automatic test_redirect();
    int n;
    do_reset(2);
    n = 0;
    while (!(out_valid === 1'b1 && out_pc === 32'h8) && n < 12) begin
      tick(1'b0, 32'h0, 1'b1); n++;
    end
    checks++;
    if (n >= 12) begin
      errors++; $display("FAIL redir_wait: got pc=%h expected pc=8 within 12 cycles", out_pc);
    end
    tick(1'b1, 32'h40, 1'b1);
    checks++;
    if (out_valid !== 1'b0 || rom_addr !== 6'd16) begin
      errors++; $display("FAIL redir_flush: got v=%b addr=%0d expected v=0 addr=16", out_valid, rom_addr);
    end
    tick(1'b0, 32'h0, 1'b1);
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'h40 || out_inst !== rom[16]) begin
      errors++; $display("FAIL redir_target: got v=%b pc=%h inst=%h expected pc=40 inst=%h", out_valid, out_pc, out_inst, rom[16]);
    end
    for (int k = 0; k < 5; k++) begin
      tick(1'b0, 32'h0, 1'b1);
      obs = get_obs(); exp = exp_obs(); checks++;
      if (obs !== exp || out_pc === 32'hC) begin
        errors++; $display("FAIL redir_stream: got %h expected %h", obs, exp);
      end
    end
  endtask

  task automatic test_wrap();
    tick(1'b1, 32'hFFFF_FFFE, 1'b1);
    checks++;
    if (out_valid !== 1'b0 || rom_addr !== 6'd63) begin
      errors++; $display("FAIL wrap_addr: got v=%b addr=%0d expected v=0 addr=63", out_valid, rom_addr);
    end
    tick(1'b0, 32'h0, 1'b1);
    checks++;
    if (out_pc !== 32'hFFFF_FFFC || out_inst !== rom[63] || rom_addr !== 6'd0) begin
      errors++; $display("FAIL wrap_top: got pc=%h addr=%0d expected pc=fffffffc addr=0", out_pc, rom_addr);
    end
    tick(1'b0, 32'h0, 1'b1);
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'h0 || out_inst !== rom[0]) begin
      errors++; $display("FAIL wrap_zero: got v=%b pc=%h expected pc=0", out_valid, out_pc);
    end
  endtask

  task automatic test_redirect_full();
    logic [31:0] tgt;
    for (int k = 0; k < 4; k++) tick(1'b0, 32'h0, 1'b0);
    tgt = $urandom & 32'h0000_00FC;
    tick(1'b1, tgt, 1'b0);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL full_flush: got v=%b expected 0", out_valid);
    end
    for (int k = 0; k < 3; k++) begin
      tick(1'b0, 32'h0, 1'b0);
      checks++;
      if (out_valid !== 1'b1 || out_pc !== tgt || out_inst !== rom[tgt[AW+1:2]]) begin
        errors++; $display("FAIL full_target: got pc=%h inst=%h expected pc=%h", out_pc, out_inst, tgt);
      end
    end
  endtask

  task automatic test_startup_redirect();
    do_reset(2);
    tick(1'b1, 32'h0000_0023, 1'b1);
    checks++;
    if (rom_addr !== 6'd8 || out_valid !== 1'b0) begin
      errors++; $display("FAIL start_redir: got addr=%0d v=%b expected addr=8 v=0", rom_addr, out_valid);
    end
    for (int k = 0; k < 4; k++) begin
      tick(1'b0, 32'h0, 1'b1);
      obs = get_obs(); exp = exp_obs(); checks++;
      if (obs !== exp) begin
        errors++; $display("FAIL start_model: got %h expected %h", obs, exp);
      end
    end
  endtask

  task automatic test_random();
    logic b;
    for (int k = 0; k < 300; k++) begin
      b = ($urandom_range(0, 5) == 0);
      tick(b, $urandom, 1'($urandom_range(0, 1)));
      obs = get_obs(); exp = exp_obs(); checks++;
      if (obs !== exp) begin
        errors++; $display("FAIL random_model: cycle %0d got %h expected %h", k, obs, exp);
      end
    end
  endtask

  task automatic test_async_reset();
    do_reset(2);
    for (int k = 0; k < 4; k++) tick(1'b0, 32'h0, 1'b0);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({out_valid, out_pc, out_inst, rom_ce} !== 66'h0) begin
      errors++; $display("FAIL async_reset: got v=%b pc=%h inst=%h ce=%b expected all 0", out_valid, out_pc, out_inst, rom_ce);
    end
    @(negedge clk);
    do_reset(2);
    for (int k = 0; k < 6; k++) begin
      tick(1'b0, 32'h0, 1'b1);
      obs = get_obs(); exp = exp_obs(); checks++;
      if (obs !== exp) begin
        errors++; $display("FAIL async_restart: got %h expected %h", obs, exp);
      end
    end
    checks++;
    if (out_pc !== 32'h10) begin
      errors++; $display("FAIL async_seq: got pc=%h expected 10", out_pc);
    end
  endtask

  initial begin
    for (int i = 0; i < (1<<AW); i++) rom[i] = $urandom;
    mq.delete(); m_pc = 32'h0; m_ce = 1'b0;
    test_reset();
    test_backpressure();
    test_redirect();
    test_wrap();
    test_redirect_full();
    test_startup_redirect();
    test_random();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
